// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, fetch-state enum and prefetch entry type for the MIPS fetch stage
//
// Purpose: common definitions for if_prefetch_unit and prefetch_fifo.
// Contents: PC_W / INSTR_W widths, NOP encoding, fetch_state_e, fetch_entry_t,
//           word_align() helper that clears the byte-offset bits of an address.
package mips_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP = '0;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_e;

    // One prefetch queue entry: the fall-through PC travels with its word.
    typedef struct packed {
        logic [PC_W-1:0]    pc_plus4;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - DEPTH-entry prefetch queue of {pc_plus4, instr} entries
//
// Purpose: small circular buffer between the fetch engine and IF/ID.
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   push, push_data   write one entry (ignored when full unless popping)
//   pop               retire the head (ignored when empty)
//   flush             empty the queue; wins over push
//   full, empty       occupancy flags
//   head              entry at the read pointer
module prefetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so push+pop on a full queue is accepted.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - instruction fetch stage with prefetch queue and redirect handling
//
// Purpose: owns the fetch PC, issues word fetches over req/ack, queues returned words
//          and presents the queue head to IF/ID; discards wrong-path fetches in flight.
// Ports:
//   clk, reset                      core clock, synchronous active-high reset
//   stall                           IF/ID holding, keep the head
//   branch_taken, branch_address    redirect (priority over jump)
//   jump, jump_address              redirect
//   instr, pc_plus4, instr_valid    queue head towards IF/ID
//   imem_req, imem_addr             fetch request, held until ack
//   imem_ack, imem_rdata            single-cycle response strobe and data
module if_prefetch_unit
    import mips_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = 10'h000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_address,
    input  logic               jump,
    input  logic [PC_W-1:0]    jump_address,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc_plus4,
    output logic               instr_valid,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            req_q, req_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [PC_W-1:0] last_pc_q, last_pc_d;

    logic            redirect;
    logic [PC_W-1:0] target;
    logic            ack;
    logic            push, pop;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    push_data, head;

    assign redirect = branch_taken | jump;
    assign target   = word_align(branch_taken ? branch_address : jump_address);

    // An ack with no request outstanding (e.g. straight after reset) is not ours.
    assign ack  = imem_ack && req_q;
    assign push = (state_q == FETCH) && ack && !redirect;
    assign pop  = !fifo_empty && !stall && !redirect;

    assign push_data.pc_plus4 = fetch_pc_q + PC_W'(4);
    assign push_data.instr    = imem_rdata;

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;

        // Request drops for one cycle after each ack; a new one launches only with room
        // in the queue, so a fetch in flight can always be pushed.
        if (req_q) begin
            if (imem_ack) begin
                req_d = 1'b0;
            end
        end else if ((state_q == FETCH) && !fifo_full && !redirect) begin
            req_d  = 1'b1;
            addr_d = fetch_pc_q;
        end

        if (push) begin
            fetch_pc_d = fetch_pc_q + PC_W'(4);
        end
        if (redirect) begin
            fetch_pc_d = target;
        end

        // A wrong-path fetch still waiting for its ack must be drained before refetching.
        if (req_q && !imem_ack && (redirect || (state_q == DISCARD))) begin
            state_d = DISCARD;
        end else begin
            state_d = FETCH;
        end
    end

    assign last_pc_d = fifo_empty ? last_pc_q : head.pc_plus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= word_align(RESET_PC);
            req_q      <= 1'b0;
            addr_q     <= word_align(RESET_PC);
            last_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            last_pc_q  <= last_pc_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? NOP : head.instr;
    assign pc_plus4    = fifo_empty ? last_pc_q : head.pc_plus4;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - self-checking bench for if_prefetch_unit
module tb_if_prefetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [9:0]  branch_address;
    logic        jump;
    logic [9:0]  jump_address;
    logic [31:0] instr;
    logic [9:0]  pc_plus4;
    logic        instr_valid;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic [31:0] w_instr;
    logic [9:0]  w_pc_plus4;
    logic        w_valid;
    logic        w_req;
    logic [9:0]  w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;

    int          total;
    int          bad;
    int          pops;
    int          acks;
    int          wcnt;
    int          lat;
    bit          lat_rand;
    bit          force_ack;
    bit          prev_hold;
    logic [9:0]  prev_addr;
    logic [9:0]  exp_pc;
    logic [9:0]  w_addrs[$];
    logic [9:0]  w_pcs[$];

    if_prefetch_unit #(.DEPTH(2), .RESET_PC(10'h000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .jump           (jump),
        .jump_address   (jump_address),
        .instr          (instr),
        .pc_plus4       (pc_plus4),
        .instr_valid    (instr_valid),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata)
    );

    if_prefetch_unit #(.DEPTH(2), .RESET_PC(10'h3F8)) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .stall          (1'b0),
        .branch_taken   (1'b0),
        .branch_address (10'h000),
        .jump           (1'b0),
        .jump_address   (10'h000),
        .instr          (w_instr),
        .pc_plus4       (w_pc_plus4),
        .instr_valid    (w_valid),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (w_ack),
        .imem_rdata     (w_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word(input logic [9:0] a);
        return 32'hA000_0000 | {22'h0, a};
    endfunction

    // One clock cycle: memory responds mid-cycle, the fetched-stream model retires
    // whatever IF/ID accepts, then the edge is taken. Returns 1 after the edge.
    task automatic cycle();
        logic       redir;
        logic [9:0] tgt;
        logic [9:0] e4;
        @(negedge clk);
        redir = branch_taken | jump;
        tgt   = branch_taken ? branch_address : jump_address;
        tgt   = tgt & 10'h3FC;
        if (reset) imem_ack = force_ack;
        else       imem_ack = force_ack || (imem_req && (wcnt >= lat));
        imem_rdata = force_ack ? 32'h5555_5555 : word(imem_addr);
        w_ack      = !reset && w_req;
        w_rdata    = word(w_addr);
        if (!reset) begin
            if (prev_hold) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    bad++;
                    $display("FAIL req_hold: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, prev_addr);
                end
            end
            if (imem_req) begin
                total++;
                if (imem_addr[1:0] !== 2'b00) begin
                    bad++;
                    $display("FAIL addr_align: addr=%h", imem_addr);
                end
            end
            if (!instr_valid) begin
                total++;
                if (instr !== 32'h0) begin
                    bad++;
                    $display("FAIL empty_nop: instr=%h want 00000000", instr);
                end
            end
            if (instr_valid && !stall && !redir) begin
                e4 = exp_pc + 10'd4;
                total++;
                if (pc_plus4 !== e4 || instr !== word(exp_pc)) begin
                    bad++;
                    $display("FAIL stream: pc_plus4=%h instr=%h want pc_plus4=%h instr=%h", pc_plus4, instr, e4, word(exp_pc));
                end
                exp_pc = e4;
                pops++;
            end
            if (redir) exp_pc = tgt;
            if (imem_req && imem_ack) acks++;
            if (w_req && w_ack) w_addrs.push_back(w_addr);
            if (w_valid) w_pcs.push_back(w_pc_plus4);
        end else begin
            exp_pc = 10'h000;
        end
        prev_hold = !reset && imem_req && !imem_ack;
        prev_addr = imem_addr;
        if (!reset && imem_req && !imem_ack) wcnt++;
        else wcnt = 0;
        if (lat_rand && imem_ack) lat = $urandom_range(0, 3);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        lat = 0;
        do_reset();
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || pc_plus4 !== 10'h000) begin
            bad++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc_plus4=%h want 0 0 0 0", imem_req, instr_valid, instr, pc_plus4);
        end
        cycle();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
            bad++;
            $display("FAIL first_req: req=%b addr=%h want 1 000", imem_req, imem_addr);
        end
        cycle();
        total++;
        if (instr_valid !== 1'b1 || pc_plus4 !== 10'h004 || instr !== word(10'h000)) begin
            bad++;
            $display("FAIL first_valid: valid=%b pc_plus4=%h instr=%h want 1 004 %h", instr_valid, pc_plus4, instr, word(10'h000));
        end
    endtask

    task automatic test_zero_wait();
        int p0;
        p0 = pops;
        repeat (20) cycle();
        total++;
        if ((pops - p0) < 9 || (pops - p0) > 10) begin
            bad++;
            $display("FAIL zero_wait_rate: pops=%0d want 9..10", pops - p0);
        end
    endtask

    task automatic test_stall_full();
        int a0;
        lat   = 3;
        do_reset();
        stall = 1'b1;
        a0    = acks;
        repeat (14) cycle();
        total++;
        if ((acks - a0) != 2 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL full_stop: acks=%0d req=%b want 2 0", acks - a0, imem_req);
        end
        total++;
        if (instr_valid !== 1'b1 || pc_plus4 !== 10'h004) begin
            bad++;
            $display("FAIL full_head0: valid=%b pc_plus4=%h want 1 004", instr_valid, pc_plus4);
        end
        stall = 1'b0;
        cycle();
        total++;
        if (instr_valid !== 1'b1 || pc_plus4 !== 10'h008) begin
            bad++;
            $display("FAIL full_head1: valid=%b pc_plus4=%h want 1 008", instr_valid, pc_plus4);
        end
    endtask

    task automatic test_branch_discard();
        int n;
        lat = 3;
        do_reset();
        n = 0;
        while (!(imem_req && imem_addr == 10'h008 && wcnt < lat) && n < 60) begin
            cycle();
            n++;
        end
        total++;
        if (n >= 60) begin
            bad++;
            $display("FAIL discard_setup: timeout waiting for fetch of 008");
        end
        branch_taken   = 1'b1;
        branch_address = 10'h041;
        cycle();
        branch_taken   = 1'b0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h008) begin
            bad++;
            $display("FAIL discard_hold: req=%b addr=%h want 1 008", imem_req, imem_addr);
        end
        n = 0;
        while (!(imem_req && imem_addr != 10'h008) && n < 30) begin
            cycle();
            n++;
        end
        total++;
        if (imem_addr !== 10'h040 || n >= 30) begin
            bad++;
            $display("FAIL discard_next_addr: addr=%h want 040", imem_addr);
        end
        n = 0;
        while (!instr_valid && n < 30) begin
            cycle();
            n++;
        end
        total++;
        if (pc_plus4 !== 10'h044 || n >= 30) begin
            bad++;
            $display("FAIL discard_next_pc: pc_plus4=%h want 044", pc_plus4);
        end
    endtask

    task automatic test_both_redirect();
        lat = 0;
        do_reset();
        cycle();
        branch_taken   = 1'b1;
        branch_address = 10'h100;
        jump           = 1'b1;
        jump_address   = 10'h200;
        cycle();
        branch_taken   = 1'b0;
        jump           = 1'b0;
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL both_drop: req=%b valid=%b want 0 0", imem_req, instr_valid);
        end
        cycle();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h100) begin
            bad++;
            $display("FAIL both_target: req=%b addr=%h want 1 100", imem_req, imem_addr);
        end
        cycle();
        total++;
        if (instr_valid !== 1'b1 || pc_plus4 !== 10'h104) begin
            bad++;
            $display("FAIL both_first: valid=%b pc_plus4=%h want 1 104", instr_valid, pc_plus4);
        end
    endtask

    task automatic test_wrap();
        logic [9:0] want_a [3];
        logic [9:0] want_p [3];
        want_a = '{10'h3F8, 10'h3FC, 10'h000};
        want_p = '{10'h3FC, 10'h000, 10'h004};
        lat = 0;
        do_reset();
        w_addrs.delete();
        w_pcs.delete();
        repeat (12) cycle();
        total++;
        if (w_addrs.size() < 3 || w_pcs.size() < 3) begin
            bad++;
            $display("FAIL wrap_count: addrs=%0d pcs=%0d want >=3", w_addrs.size(), w_pcs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (w_addrs[i] !== want_a[i] || w_pcs[i] !== want_p[i]) begin
                    bad++;
                    $display("FAIL wrap_%0d: addr=%h pc_plus4=%h want %h %h", i, w_addrs[i], w_pcs[i], want_a[i], want_p[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midwait();
        int n;
        lat = 3;
        do_reset();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            bad++;
            $display("FAIL midwait_reset: req=%b valid=%b instr=%h want 0 0 0", imem_req, instr_valid, instr);
        end
        reset     = 1'b0;
        force_ack = 1'b1;
        cycle();
        force_ack = 1'b0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h000 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL late_ack: req=%b addr=%h valid=%b want 1 000 0", imem_req, imem_addr, instr_valid);
        end
        n = 0;
        while (!instr_valid && n < 30) begin
            cycle();
            n++;
        end
        total++;
        if (pc_plus4 !== 10'h004 || n >= 30) begin
            bad++;
            $display("FAIL midwait_restart: pc_plus4=%h want 004", pc_plus4);
        end
    endtask

    task automatic test_random();
        int p0;
        int r;
        lat_rand = 1'b1;
        lat      = 1;
        do_reset();
        p0 = pops;
        repeat (500) begin
            stall          = ($urandom_range(0, 2) == 0);
            r              = $urandom_range(0, 24);
            branch_taken   = (r == 0) || (r == 2);
            jump           = (r == 1) || (r == 2);
            branch_address = 10'($urandom_range(0, 1023));
            jump_address   = 10'($urandom_range(0, 1023));
            cycle();
        end
        stall        = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        lat_rand     = 1'b0;
        total++;
        if ((pops - p0) < 30) begin
            bad++;
            $display("FAIL random_progress: pops=%0d want >=30", pops - p0);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        pops           = 0;
        acks           = 0;
        wcnt           = 0;
        lat            = 0;
        lat_rand       = 1'b0;
        force_ack      = 1'b0;
        prev_hold      = 1'b0;
        prev_addr      = 10'h000;
        exp_pc         = 10'h000;
        reset          = 1'b1;
        stall          = 1'b0;
        branch_taken   = 1'b0;
        branch_address = 10'h000;
        jump           = 1'b0;
        jump_address   = 10'h000;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        w_ack          = 1'b0;
        w_rdata        = 32'h0;

        test_reset();
        test_zero_wait();
        test_stall_full();
        test_branch_discard();
        test_both_redirect();
        test_wrap();
        test_reset_midwait();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Instruction-fetch stage feeding the IF/ID pipeline register of the 5-stage MIPS core.
- Owns the 10-bit PC and issues word fetches to a variable-latency instruction memory over a req/ack handshake.
- Buffers fetched words in a small prefetch queue and presents the head {pc_plus4, instr} to IF/ID.
- Honours pipeline stall and branch/jump redirects from ID, discarding wrong-path fetches that are still in flight.

Parameters:
- DEPTH, 2, prefetch queue entries (power of two, ≥2).
- RESET_PC, 10'h000, byte address of the first fetch.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  1 = IF/ID is holding; do not pop the queue head
- branch_taken  in  1  redirect to branch_address
- branch_address  in  10  branch target, byte address
- jump  in  1  redirect to jump_address
- jump_address  in  10  jump target, byte address
- instr  out  32  queue-head instruction; 32'h0 (NOP) when the queue is empty
- pc_plus4  out  10  queue-head fetch address + 4
- instr_valid  out  1  queue head valid
- imem_req  out  1  fetch request
- imem_addr  out  10  fetch byte address, word aligned
- imem_ack  in  1  one-cycle response strobe; imem_rdata is valid in the same cycle
- imem_rdata  in  32  fetched word

Behaviour:
- Reset (sync, active-high), on the next edge:
  - fetch_pc = RESET_PC; queue empty; state = FETCH.
  - imem_req = 0, instr_valid = 0, instr = 0, pc_plus4 = 0.
  - The memory shares this reset. An imem_ack that arrives while imem_req is low is ignored.
- Address arithmetic: all 10-bit modulo 1024, so 10'h3FC + 4 = 10'h000. Bits [1:0] of imem_addr are always 0; target bits [1:0] are forced to 0.
- Handshake:
  - Once imem_req rises, imem_req and imem_addr stay stable until the cycle imem_ack = 1 (inclusive).
  - At most one request is outstanding.
  - A new request may start the cycle after an ack (zero-gap back-to-back is not required).
- States:
  - FETCH: imem_req = 1 whenever queue count < DEPTH. On ack, push {fetch_pc + 4, imem_rdata} and set fetch_pc += 4.
  - DISCARD: imem_req held with the stale address. On ack, drop the data and return to FETCH. fetch_pc already holds the redirect target.
- Pop: when instr_valid && !stall && no redirect this cycle. Push and pop in the same cycle are both performed; count is unchanged.
- Redirect (branch_taken | jump):
  - branch_taken has priority if both are asserted.
  - On the next edge: queue flushed; fetch_pc = target; any push in that cycle is suppressed.
  - If a request is outstanding and not acked in the redirect cycle → DISCARD.
  - If the ack coincides with the redirect → FETCH; the data is dropped.
  - A redirect while already in DISCARD updates fetch_pc only.
  - A redirect overrides stall.
- Full: with count == DEPTH no new request is raised. A request already in flight always has room, because it launched only when count < DEPTH.
- Empty: instr_valid = 0, instr = 0, pc_plus4 holds its last value.
- Latency: for an ack in cycle N, instr_valid = 1 in cycle N+1. Zero-wait memory gives 1 instruction per 2 cycles.

Decomposition:
- Shared package (mips_pkg): PC_W = 10, INSTR_W = 32, NOP = 32'h0, fetch-state enum {FETCH, DISCARD}.
- One sub-module: prefetch_fifo (DEPTH entries × 42 bits). Ports: push, pop, flush, full, empty, head. Simultaneous push+pop is legal when full or empty. Flush has priority over push.

Test Plan:
- Reset, then zero-wait memory returning rdata = addr|32'hA000_0000 → imem_addr 0,4,8…; instr_valid first rises 2 cycles after reset release; pc_plus4 4,8,12 in order.
- Memory ack delay of 3 cycles, stall = 1 for 10 cycles → exactly 2 entries fetched, imem_req low while full. Release stall → heads pc_plus4 = 4 then 8, no loss or duplicate.
- branch_taken with branch_address = 10'h040 while a request to 10'h008 is outstanding → DISCARD; the 0x008 data never appears; next imem_addr = 10'h040; next valid pc_plus4 = 10'h044.
- branch_taken and jump in the same cycle (targets 10'h100, 10'h200) → fetch from 10'h100; ack coinciding with the redirect is dropped.
- Start at RESET_PC = 10'h3F8 → addresses 3F8, 3FC, 000; pc_plus4 wraps 3FC → 000 → 004.
- Reset asserted mid-wait (req high, no ack) → next cycle imem_req = 0, queue empty; a late ack with req low is ignored; fetch restarts at RESET_PC.
